// File: rtl/slice_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : slice_pkg                                                   |
// | Purpose  : shared types and helpers for the space-to-depth scheduler   |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
package slice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Phase = {row parity, column parity} of the source pixel
  localparam logic [1:0] C_PH_EE = 2'd0;
  localparam logic [1:0] C_PH_EO = 2'd1;
  localparam logic [1:0] C_PH_OE = 2'd2;
  localparam logic [1:0] C_PH_OO = 2'd3;

  // Ceiling log2, never less than 1 so it can size a vector directly
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/slice_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : slice_fifo                                                  |
// | Purpose  : synchronous show-ahead FIFO, head entry visible on dout     |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module slice_fifo
  import slice_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [clog2(DEPTH+1)-1:0]  count
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/slice_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : slice_sched                                                 |
// | Purpose  : address-generating space-to-depth slice sequencer           |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module slice_sched
  import slice_pkg::*;
#(
  parameter int LAYER_num       = 1,
  parameter int WIDTH_in_data   = 160,
  parameter int WIDTH_each_data = 16,
  parameter int RD_LAT          = 1,
  parameter int ADDR_W          = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic [WIDTH_each_data-1:0]    rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH_each_data-1:0]    out_data,
  output logic [1:0]                    out_phase,
  output logic [clog2(LAYER_num)-1:0]   out_layer,
  output logic                          out_last,
  output logic                          out_frame_last
);

  localparam int WIDTH_out_data = WIDTH_in_data / 2;
  localparam int FIFO_DEPTH     = RD_LAT + 2;
  localparam int LW             = clog2(LAYER_num);
  localparam int MW             = clog2(WIDTH_out_data);
  localparam int OW             = clog2(FIFO_DEPTH + 1);
  localparam int TW             = 2 + LW + 2;
  localparam int EW             = WIDTH_each_data + TW;

  localparam logic [ADDR_W-1:0] c_plane = ADDR_W'(WIDTH_in_data * WIDTH_in_data);
  localparam logic [ADDR_W-1:0] c_row   = ADDR_W'(WIDTH_in_data);

  state_t            r_state;
  state_t            w_state_next;
  logic [1:0]        r_phase;
  logic [LW-1:0]     r_layer;
  logic [MW-1:0]     r_m;
  logic [MW-1:0]     r_n;
  logic [OW-1:0]     r_outst;
  logic [OW-1:0]     w_outst_next;
  logic              w_rd_en;
  logic              w_busy;
  logic              w_done;
  logic              w_drained;
  logic              w_n_last;
  logic              w_m_last;
  logic              w_layer_last;
  logic              w_phase_last;
  logic              w_frame_last;
  logic [TW-1:0]     w_tag;
  logic [ADDR_W-1:0] w_addr;
  logic [RD_LAT-1:0] r_vld_pipe;
  logic [TW-1:0]     r_tag_pipe [RD_LAT];
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [OW-1:0]     w_fifo_count;
  logic [EW-1:0]     w_fifo_dout;

  assign w_n_last     = (r_n == MW'(WIDTH_out_data - 1));
  assign w_m_last     = (r_m == MW'(WIDTH_out_data - 1));
  assign w_layer_last = (r_layer == LW'(LAYER_num - 1));
  assign w_phase_last = w_layer_last & w_m_last & w_n_last;
  assign w_frame_last = w_phase_last & (r_phase == C_PH_OO);
  assign w_tag        = {r_phase, r_layer, w_phase_last, w_frame_last};

  // {m, phase bit} is 2m + parity, i.e. the source row/column directly
  assign w_addr = ADDR_W'(r_layer) * c_plane
                + ADDR_W'({r_m, r_phase[1]}) * c_row
                + ADDR_W'({r_n, r_phase[0]});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase <= C_PH_EE;
      r_layer <= '0;
      r_m     <= '0;
      r_n     <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_phase <= C_PH_EE;
      r_layer <= '0;
      r_m     <= '0;
      r_n     <= '0;
    end else if (w_rd_en) begin
      if (w_n_last) begin
        r_n <= '0;
        if (w_m_last) begin
          r_m <= '0;
          if (w_layer_last) begin
            r_layer <= '0;
            r_phase <= r_phase + 2'd1;
          end else begin
            r_layer <= r_layer + LW'(1);
          end
        end else begin
          r_m <= r_m + MW'(1);
        end
      end else begin
        r_n <= r_n + MW'(1);
      end
    end
  end

  // Reads issued but not yet popped; bounds FIFO occupancy by construction
  always_comb begin
    w_outst_next = r_outst;
    if (w_rd_en && !w_pop)      w_outst_next = r_outst + OW'(1);
    else if (!w_rd_en && w_pop) w_outst_next = r_outst - OW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_outst <= '0;
    else       r_outst <= w_outst_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) r_tag_pipe[i] <= '0;
    end else begin
      r_vld_pipe[0] <= w_rd_en;
      r_tag_pipe[0] <= w_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_tag_pipe[i] <= r_tag_pipe[i-1];
      end
    end
  end

  assign w_push = r_vld_pipe[RD_LAT-1];
  assign w_pop  = ~w_fifo_empty & out_ready;

  slice_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (w_push),
    .din   ({rd_data, r_tag_pipe[RD_LAT-1]}),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .empty (w_fifo_empty),
    .full  (w_fifo_full),
    .count (w_fifo_count)
  );

  // Looks one cycle ahead so DONE follows the final handshake directly
  assign w_drained = (r_vld_pipe == '0) && (w_fifo_count == OW'(w_pop));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_rd_en = (r_outst < OW'(FIFO_DEPTH)) & ~w_fifo_full;
        if (w_rd_en && w_frame_last) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_drained) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign busy      = w_busy;
  assign done      = w_done;
  assign rd_en     = w_rd_en;
  assign rd_addr   = w_rd_en ? w_addr : '0;
  assign out_valid = ~w_fifo_empty;
  assign {out_data, out_phase, out_layer, out_last, out_frame_last} = w_fifo_dout;

endmodule
`default_nettype wire
